// File: rtl/ex_div_unit_pkg.sv
// Shared constants and state codes for the EX-stage divider.
package ex_div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_CNT_W = 6;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

endpackage

// File: rtl/ex_div_unit_if.sv
// EX-to-divider request/response bundle; EX is the master, the divider the slave.
interface ex_div_unit_if
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) ();

    logic                 start;
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic                 annul;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 stallreq_for_div;

    modport master (
        output start, signed_div, opdata1, opdata2, annul,
        input  result, ready, stallreq_for_div
    );

    modport slave (
        input  start, signed_div, opdata1, opdata2, annul,
        output result, ready, stallreq_for_div
    );

endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    ex_div_unit_if.slave bus
);

    localparam int unsigned W = WIDTH;

    div_state_e         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*W:0]       r_work;      // {partial remainder (W+1), quotient (W)}
    logic [W-1:0]       r_divisor;
    logic               r_neg_quo;
    logic               r_neg_rem;
    logic [2*W-1:0]     r_result;
    logic               r_ready;

    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [W-1:0]       w_mag1;
    logic [W-1:0]       w_mag2;
    logic               w_accept;
    logic [2*W:0]       w_shift;
    logic [W+1:0]       w_diff;
    logic               w_borrow;
    logic [2*W:0]       w_step;
    logic [W-1:0]       w_quo;
    logic [W-1:0]       w_rem;
    logic [W-1:0]       w_quo_fix;
    logic [W-1:0]       w_rem_fix;
    logic               w_last;

    // Operand magnitudes for signed division; signs are kept separately for the fix-up
    assign w_op1_neg = bus.signed_div & bus.opdata1[W-1];
    assign w_op2_neg = bus.signed_div & bus.opdata2[W-1];
    assign w_mag1    = w_op1_neg ? -bus.opdata1 : bus.opdata1;
    assign w_mag2    = w_op2_neg ? -bus.opdata2 : bus.opdata2;
    assign w_accept  = (bus.start == DIV_START) & ~bus.annul;

    // One restoring step: shift, trial-subtract on the upper W+1 bits, borrow selects restore
    assign w_shift  = r_work << 1;
    assign w_diff   = {1'b0, w_shift[2*W:W]} - {2'b00, r_divisor};
    assign w_borrow = w_diff[W+1];
    assign w_step   = w_borrow ? w_shift : {w_diff[W:0], w_shift[W-1:1], 1'b1};

    // Sign fix-up applied as the final step is written into the result
    assign w_quo     = w_step[W-1:0];
    assign w_rem     = w_step[2*W-1:W];
    assign w_quo_fix = r_neg_quo ? -w_quo : w_quo;
    assign w_rem_fix = r_neg_rem ? -w_rem : w_rem;
    assign w_last    = (r_cnt == CNT_W'(W - 1));

    // Stall IF..EX from acceptance until the result is ready; released in END
    assign bus.stallreq_for_div = ((r_state == DIV_FREE) & w_accept)
                                | (r_state == DIV_BY_ZERO)
                                | (r_state == DIV_ON);
    assign bus.result = r_result;
    assign bus.ready  = r_ready;

    // Divider FSM with registered result/ready; annul outranks start and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_work    <= '0;
            r_divisor <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            r_result  <= '0;
            r_ready   <= DIV_RESULT_NOT_READY;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    r_result <= '0;
                    r_ready  <= DIV_RESULT_NOT_READY;
                    if (w_accept) begin
                        r_neg_quo <= w_op1_neg ^ w_op2_neg;
                        r_neg_rem <= w_op1_neg;
                        r_divisor <= w_mag2;
                        r_cnt     <= '0;
                        if (bus.opdata2 == '0) begin
                            r_work  <= {{(W+1){1'b0}}, bus.opdata1};
                            r_state <= DIV_BY_ZERO;
                        end else begin
                            r_work  <= {{(W+1){1'b0}}, w_mag1};
                            r_state <= DIV_ON;
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (bus.annul) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_result <= {r_work[W-1:0], {W{1'b1}}};
                        r_ready  <= DIV_RESULT_READY;
                        r_state  <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (bus.annul) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_work <= w_step;
                        r_cnt  <= r_cnt + CNT_W'(1);
                        if (w_last) begin
                            r_result <= {w_rem_fix, w_quo_fix};
                            r_ready  <= DIV_RESULT_READY;
                            r_state  <= DIV_END;
                        end
                    end
                end
                DIV_END: begin
                    if (bus.annul || (bus.start == DIV_STOP)) begin
                        r_result <= '0;
                        r_ready  <= DIV_RESULT_NOT_READY;
                        r_state  <= DIV_FREE;
                    end
                end
                default: begin
                    r_state <= DIV_FREE;
                end
            endcase
        end
    end

endmodule
